// File: rtl/riscv_mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto a single memory port.
// One transaction in flight at a time; data has priority unless a waiting fetch has starved.
module riscv_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_rd_en,
  input  logic [31:0] inst_addr,
  output logic        instr_ready,
  output logic [31:0] instr_data,
  input  logic        data_rd_en_ma,
  input  logic        data_wr_en_ma,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_rd_en_ctrl,
  output logic        data_ready,
  output logic [31:0] data_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        busy
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SW-1:0]  r_starve;
  logic [WW-1:0]  r_wait_cnt;
  logic           r_is_fetch;
  logic           r_we;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic [3:0]     r_be;
  logic           r_err;
  logic [31:0]    r_instr_data;
  logic [31:0]    r_data_rd;

  logic           w_data_req;
  logic           w_fetch_wins;
  logic           w_grant;
  logic           w_timeout;
  logic [31:0]    w_resp_data;

  assign w_data_req   = data_rd_en_ma | data_wr_en_ma;
  assign w_fetch_wins = inst_rd_en & (~w_data_req | (r_starve == STARVE_LIM));
  assign w_grant      = (r_state == S_IDLE) & (inst_rd_en | w_data_req);
  assign w_timeout    = (r_wait_cnt == WAIT_LAST);
  assign w_resp_data  = mem_rvalid ? mem_rdata : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: if (mem_gnt) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_rvalid || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Starve count only tracks data wins that happen while a fetch is actually waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (!inst_rd_en) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (w_fetch_wins)                r_starve <= '0;
      else if (r_starve != STARVE_LIM) r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT && w_state_nxt == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_fetch <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else if (w_grant) begin
      r_is_fetch <= w_fetch_wins;
      r_we       <= ~w_fetch_wins & data_wr_en_ma;
      r_addr     <= w_fetch_wins ? inst_addr : data_addr;
      r_wdata    <= (~w_fetch_wins & data_wr_en_ma) ? data_wr : '0;
      r_be       <= w_fetch_wins ? 4'hF : data_rd_en_ctrl;
    end
  end

  // Read-data outputs load on WAIT->RESP so they are valid during RESP and hold afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err        <= 1'b0;
      r_instr_data <= '0;
      r_data_rd    <= '0;
    end else if (r_state == S_WAIT && w_state_nxt == S_RESP) begin
      r_err <= ~mem_rvalid;
      if (r_is_fetch) r_instr_data <= w_resp_data;
      else            r_data_rd    <= w_resp_data;
    end
  end

  assign mem_req     = (r_state == S_ISSUE);
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_be      = r_be;
  assign instr_ready = (r_state == S_RESP) & r_is_fetch;
  assign data_ready  = (r_state == S_RESP) & ~r_is_fetch;
  assign bus_err     = (r_state == S_RESP) & r_err;
  assign busy        = (r_state != S_IDLE);
  assign instr_data  = r_instr_data;
  assign data_rd     = r_data_rd;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: expected issues/responses queued at stimulus time,
// checked by a memory responder and a ready monitor.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_en;
  logic [31:0] inst_addr;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        data_rd_en_ma;
  logic        data_wr_en_ma;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_rd_en_ctrl;
  logic        data_ready;
  logic [31:0] data_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        busy;

  riscv_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .inst_rd_en(inst_rd_en), .inst_addr(inst_addr),
    .instr_ready(instr_ready), .instr_data(instr_data),
    .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
    .data_addr(data_addr), .data_wr(data_wr), .data_rd_en_ctrl(data_rd_en_ctrl),
    .data_ready(data_ready), .data_rd(data_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } iss_t;
  typedef struct { logic fetch; logic chkd; logic [31:0] data; logic err; } rsp_t;

  iss_t q_iss[$];
  rsp_t q_rsp[$];

  int n_total = 0;
  int n_bad   = 0;
  int gnt_delay = 0;
  int rv_delay  = 0;
  bit rsp_en    = 1'b1;
  logic prev_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic void push_iss(input logic [31:0] a, input logic we, input logic [3:0] be,
                                   input logic [31:0] wd);
    iss_t e;
    e.addr = a; e.we = we; e.be = be; e.wdata = wd;
    q_iss.push_back(e);
  endfunction

  function automatic void push_rsp(input logic f, input logic chkd, input logic [31:0] d,
                                   input logic err);
    rsp_t e;
    e.fetch = f; e.chkd = chkd; e.data = d; e.err = err;
    q_rsp.push_back(e);
  endfunction

  // Memory responder: checks each issued request, then grants and answers it.
  initial begin
    iss_t e;
    logic [31:0] a;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        check("iss_q_empty", 32'(q_iss.size() == 0), 32'd0);
        if (q_iss.size() != 0) begin
          e = q_iss.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", mem_we, e.we);
          check("mem_be", mem_be, e.be);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
        a = mem_addr;
        for (int i = 0; i < gnt_delay; i++) begin
          @(negedge clk);
          check("req_hold", mem_req, 1'b1);
          check("addr_hold", mem_addr, a);
          check("no_rdy_hold", instr_ready | data_ready, 1'b0);
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        if (rsp_en) begin
          for (int i = 0; i < rv_delay; i++) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1; mem_rdata = mem_fn(a);
          @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
      end
    end
  end

  // Ready monitor: every completion pulse must match the next queued response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (instr_ready || data_ready)) begin
        check("rdy_both", instr_ready & data_ready, 1'b0);
        check("rdy_1cyc", prev_rdy, 1'b0);
        check("rsp_q_empty", 32'(q_rsp.size() == 0), 32'd0);
        if (q_rsp.size() != 0) begin
          r = q_rsp.pop_front();
          check("rdy_kind", instr_ready, r.fetch);
          if (r.chkd) check("rdy_data", r.fetch ? instr_data : data_rd, r.data);
          check("rdy_bus_err", bus_err, r.err);
        end
      end else if (bus_err === 1'b1) begin
        check("err_alone", bus_err, 1'b0);
      end
      prev_rdy = instr_ready | data_ready;
    end
  end

  task automatic do_req(input bit fetch, input bit we, input bit both, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, output int lat);
    lat = -1;
    if (fetch) begin
      inst_addr = addr; inst_rd_en = 1'b1;
    end else begin
      data_addr = addr; data_wr = wd; data_rd_en_ctrl = be;
      data_wr_en_ma = we; data_rd_en_ma = !we || both;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fetch ? instr_ready : data_ready) begin lat = i; break; end
    end
    if (fetch) inst_rd_en = 1'b0;
    else begin data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0; end
    check(fetch ? "fetch_done" : "data_done", 32'(lat >= 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation bound exceeded at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2;
    reset = 1'b0;
    inst_rd_en = 1'b0; inst_addr = '0;
    data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0;
    data_addr = '0; data_wr = '0; data_rd_en_ctrl = '0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", {instr_ready, data_ready, bus_err}, 3'b000);
    check("rst_idata", instr_data, 32'h0);
    check("rst_drd", data_rd, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Minimum-latency fetch, then a load, then hold of read data outside RESP.
    push_iss(32'h100, 1'b0, 4'hF, '0);
    push_rsp(1'b1, 1'b1, 32'h0000_0013, 1'b0);
    @(posedge clk); #1 do_req(1'b1, 1'b0, 1'b0, 32'h100, '0, 4'h0, lat);
    check("lat_fetch", lat, 32'd3);
    push_iss(32'h40, 1'b0, 4'b1100, '0);
    push_rsp(1'b0, 1'b1, mem_fn(32'h40), 1'b0);
    @(posedge clk); #1 do_req(1'b0, 1'b0, 1'b0, 32'h40, '0, 4'b1100, lat);
    check("lat_load", lat, 32'd3);
    repeat (2) @(negedge clk);
    check("hold_idata", instr_data, 32'h0000_0013);
    check("hold_drd", data_rd, mem_fn(32'h40));

    // Fetch and store together: store first.
    push_iss(32'h2000, 1'b1, 4'b0011, 32'hCAFE_BABE);
    push_iss(32'h104, 1'b0, 4'hF, '0);
    push_rsp(1'b0, 1'b0, '0, 1'b0);
    push_rsp(1'b1, 1'b1, mem_fn(32'h104), 1'b0);
    @(posedge clk); #1;
    fork
      do_req(1'b0, 1'b1, 1'b0, 32'h2000, 32'hCAFE_BABE, 4'b0011, lat);
      do_req(1'b1, 1'b0, 1'b0, 32'h104, '0, 4'h0, lat2);
    join

    // Read and write enables both high behave as a store.
    push_iss(32'h2100, 1'b1, 4'b1000, 32'h1234_5678);
    push_rsp(1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1 do_req(1'b0, 1'b1, 1'b1, 32'h2100, 32'h1234_5678, 4'b1000, lat);

    // Starvation: four data grants, then the waiting fetch.
    for (int k = 0; k < 4; k++) begin
      push_iss(32'h400 + 32'(k * 4), 1'b0, 4'hF, '0);
      push_rsp(1'b0, 1'b1, mem_fn(32'h400 + 32'(k * 4)), 1'b0);
    end
    push_iss(32'h200, 1'b0, 4'hF, '0);
    push_rsp(1'b1, 1'b1, mem_fn(32'h200), 1'b0);
    for (int k = 4; k < 6; k++) begin
      push_iss(32'h400 + 32'(k * 4), 1'b0, 4'hF, '0);
      push_rsp(1'b0, 1'b1, mem_fn(32'h400 + 32'(k * 4)), 1'b0);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int l;
          do_req(1'b0, 1'b0, 1'b0, 32'h400 + 32'(k * 4), '0, 4'hF, l);
        end
      end
      do_req(1'b1, 1'b0, 1'b0, 32'h200, '0, 4'h0, lat2);
    join

    // Grant withheld for 10 cycles.
    gnt_delay = 10;
    push_iss(32'h800, 1'b0, 4'b0101, '0);
    push_rsp(1'b0, 1'b1, mem_fn(32'h800), 1'b0);
    @(posedge clk); #1 do_req(1'b0, 1'b0, 1'b0, 32'h800, '0, 4'b0101, lat);
    check("lat_gnt10", lat, 32'd13);
    gnt_delay = 0;

    // No response: timeout aborts with zero data and bus_err.
    rsp_en = 1'b0;
    push_iss(32'h3000, 1'b0, 4'hF, '0);
    push_rsp(1'b0, 1'b1, 32'h0, 1'b1);
    @(posedge clk); #1 do_req(1'b0, 1'b0, 1'b0, 32'h3000, '0, 4'hF, lat);
    check("lat_timeout_ok", 32'(lat >= int'(TO) + 1 && lat <= int'(TO) + 3), 32'd1);
    @(negedge clk);
    check("to_idle_busy", busy, 1'b0);
    check("to_hold_drd", data_rd, 32'h0);
    rsp_en = 1'b1;

    // Reset during WAIT; the late response lands in IDLE and must be ignored.
    rv_delay = 6;
    push_iss(32'h5000, 1'b0, 4'hF, '0);
    @(posedge clk); #1;
    data_addr = 32'h5000; data_rd_en_ctrl = 4'hF; data_rd_en_ma = 1'b1;
    repeat (3) @(negedge clk);
    check("wait_busy", busy, 1'b1);
    #2 reset = 1'b0; data_rd_en_ma = 1'b0;
    #1;
    check("rstw_mem_req", mem_req, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_drd", data_rd, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_rdy", data_ready | instr_ready, 1'b0);
    end
    rv_delay = 0;

    check("iss_q_left", q_iss.size(), 32'd0);
    check("rsp_q_left", q_rsp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameters SHALL be: STARVE_MAX, default 4, max consecutive data grants while a fetch waits; TIMEOUT, default 255, max WAIT cycles before abort.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 inst_rd_en  in  1  fetch request, held until instr_ready.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 instr_ready  out  1  one-cycle fetch completion pulse.
REQ-007 instr_data  out  32  fetched word, valid with instr_ready.
REQ-008 data_rd_en_ma / data_wr_en_ma  in  1 each  load / store request, held until data_ready.
REQ-009 data_addr, data_wr  in  32 each  data address, store data.
REQ-010 data_rd_en_ctrl  in  4  byte enables for load and store.
REQ-011 data_ready  out  1  one-cycle data completion pulse.
REQ-012 data_rd  out  32  load data, valid with data_ready.
REQ-013 mem_req, mem_we  out  1 each  unified memory request, write flag.
REQ-014 mem_addr, mem_wdata  out  32 each; mem_be  out  4.
REQ-015 mem_gnt  in  1  memory accepts request this cycle.
REQ-016 mem_rvalid  in  1  response (read data or write ack); mem_rdata  in  32.
REQ-017 bus_err  out  1  one-cycle pulse with the ready of a timed-out transaction; busy  out  1  high in any state but IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-019 IDLE: if any request pending, latch winner's address/data/be/we, go ISSUE; else stay.
REQ-020 Arbitration: data wins over fetch unless starve counter equals STARVE_MAX, then fetch wins.
REQ-021 Starve counter SHALL increment on each data grant while inst_rd_en high, clear on a fetch grant or when inst_rd_en low, saturate at STARVE_MAX.
REQ-022 Fetch: mem_we=0, mem_be=4'hF. Load: mem_we=0. Store: mem_we=1, mem_wdata=data_wr. Load/store: mem_be=data_rd_en_ctrl.
REQ-023 data_rd_en_ma and data_wr_en_ma both high SHALL be treated as a store.
REQ-024 ISSUE: mem_req=1, mem_addr/we/wdata/be held stable from latch; on mem_gnt go WAIT and drop mem_req next cycle.
REQ-025 WAIT: on mem_rvalid capture mem_rdata, go RESP; wait counter increments each WAIT cycle.
REQ-026 Wait counter reaching TIMEOUT without mem_rvalid SHALL go RESP with data 32'h0 and bus_err asserted in RESP.
REQ-027 RESP: exactly one of instr_ready/data_ready high per owner, read data on instr_data/data_rd; no arbitration; next state IDLE.
REQ-028 Minimum latency: request seen in IDLE cycle 0, mem_req cycle 1, rvalid cycle 2 (gnt cycle 1), ready cycle 3.
REQ-029 mem_rvalid in IDLE, ISSUE, or RESP SHALL be ignored.
REQ-030 instr_data/data_rd SHALL hold last value outside RESP; ready pulses never exceed one cycle.

Reset
REQ-031 reset low SHALL force IDLE immediately; zero all outputs, starve/wait counters, latched request.
REQ-032 Reset mid-transaction SHALL drop mem_req asynchronously; a later mem_rvalid in IDLE is ignored.

Verification
REQ-033 Fetch 0x100, mem_gnt same cycle, rvalid next with 0x00000013 -> instr_ready cycle 3, instr_data 0x00000013.
REQ-034 Fetch and store (0x2000, 0xCAFEBABE, be 4'b0011) both high at cycle 0 -> store issued first, mem_we=1, mem_be=4'b0011; fetch issued after data_ready.
REQ-035 Data requests continuous with fetch pending, STARVE_MAX=4 -> 4 data grants, 5th grant to fetch.
REQ-036 mem_gnt withheld 10 cycles -> mem_req and mem_addr stable 10 cycles, no ready pulse.
REQ-037 No mem_rvalid for TIMEOUT=255 cycles -> data_ready and bus_err together one cycle, data_rd=0, then IDLE.
REQ-038 reset asserted in WAIT, rvalid arrives after release -> mem_req 0 immediately, no ready pulse, busy 0.
